// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared operation type and chunk sizing for the pipelined adder/subtractor
package pipelined_addsub_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_addsub_stage.sv
// addsub_stage: one carry chunk of the adder plus its valid/ready register slice
module addsub_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4,
  parameter int K      = 0,
  parameter int PW     = 3 * WIDTH + TAG_W + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pl
);
  localparam int C = chunk_w(WIDTH, STAGES);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    op_e              op;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] a;
  } pl_t;
  pl_t p, nxt, pl_d, pl_q;
  logic v_d, v_q, co;
  logic [C-1:0] s;
  assign p = pl_t'(in_pl);
  assign {co, s} = {1'b0, p.a[K*C +: C]} + {1'b0, p.bp[K*C +: C]} + {{C{1'b0}}, p.c};
  // an empty slice accepts even when downstream is stalled, collapsing bubbles
  assign in_ready = !v_q || out_ready;
  always_comb begin
    nxt = p;
    nxt.sum[K*C +: C] = s;
    nxt.c = co;
    v_d = in_ready ? in_valid : v_q;
    pl_d = (in_ready && in_valid) ? nxt : pl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      pl_q <= '0;
    end else begin
      v_q <= v_d;
      pl_q <= pl_d;
    end
  end
  assign out_valid = v_q;
  assign out_pl = pl_q;
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: carry-chunked pipelined add/sub with valid/ready on both sides.
// Define PIPELINED_ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    op_e              op;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] a;
  } pl_t;
  localparam int PW = $bits(pl_t);
  logic [STAGES:0] v, rdy;
  logic [STAGES:0][PW-1:0] pl;
  pl_t p0, fin;
  logic ovf, unused_fin;
  // subtraction is a + ~b + ~cin, so invert once at entry and reuse the adder chain
  always_comb begin
    p0 = '0;
    p0.a = in_a;
    p0.op = in_sub ? OP_SUB : OP_ADD;
    p0.bp = (p0.op == OP_SUB) ? ~in_b : in_b;
    p0.c = (p0.op == OP_SUB) ? ~in_cin : in_cin;
    p0.tag = in_tag;
  end
  assign v[0] = in_valid;
  assign pl[0] = p0;
  assign rdy[STAGES] = out_ready;
  assign in_ready = rdy[0] && !rst;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    addsub_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .TAG_W (TAG_W),
      .K     (k),
      .PW    (PW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v[k]),
      .in_ready (rdy[k]),
      .in_pl    (pl[k]),
      .out_valid(v[k+1]),
      .out_ready(rdy[k+1]),
      .out_pl   (pl[k+1])
    );
  end
  assign fin = pl_t'(pl[STAGES]);
  assign ovf = (fin.a[WIDTH-1] == fin.bp[WIDTH-1]) && (fin.sum[WIDTH-1] != fin.a[WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
  assign out_sum = ovf ? {fin.a[WIDTH-1], {(WIDTH-1){~fin.a[WIDTH-1]}}} : fin.sum;
`else
  assign out_sum = fin.sum;
`endif
  assign out_valid = v[STAGES];
  assign out_cout = fin.c;
  assign out_ovf = ovf;
  assign out_tag = fin.tag;
  assign unused_fin = ^{fin.a[WIDTH-2:0], fin.bp[WIDTH-2:0], fin.op};
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: table, directed and randomized checks against an arithmetic reference model
module tb_pipelined_addsub;
  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [3:0]  tag;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 1;
  logic [31:0] in_a = 0, in_b = 0;
  logic [3:0] in_tag = 0;
  logic in_ready, out_valid, out_cout, out_ovf;
  logic [31:0] out_sum;
  logic [3:0] out_tag;
  logic s1_valid, s1_cout, s32_valid, s32_cout;
  logic [31:0] s1_sum, s32_sum;
  logic unused_s1_rdy, unused_s1_ovf, unused_s32_rdy, unused_s32_ovf;
  logic [3:0] unused_s1_tag, unused_s32_tag;

  int checks = 0, fails = 0;
  vec_t src[$], exq[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag));

  pipelined_addsub #(.WIDTH(32), .STAGES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_s1_rdy), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(s1_valid), .out_ready(1'b1),
    .out_sum(s1_sum), .out_cout(s1_cout), .out_ovf(unused_s1_ovf), .out_tag(unused_s1_tag));

  pipelined_addsub #(.WIDTH(32), .STAGES(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_s32_rdy), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag), .out_valid(s32_valid), .out_ready(1'b1),
    .out_sum(s32_sum), .out_cout(s32_cout), .out_ovf(unused_s32_ovf), .out_tag(unused_s32_tag));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // signed/unsigned results computed with wide integer arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint s, ss;
    s = v.sub ? longint'(v.a) - longint'(v.b) - longint'(v.cin)
              : longint'(v.a) + longint'(v.b) + longint'(v.cin);
    ss = v.sub ? longint'($signed(v.a)) - longint'($signed(v.b)) - longint'(v.cin)
               : longint'($signed(v.a)) + longint'($signed(v.b)) + longint'(v.cin);
    r.sum = s[31:0];
    r.cout = v.sub ? (s >= 0) : s[32];
    r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (r.ovf) r.sum = v.a[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, b, input logic cin, sub, input logic [3:0] tag,
                              input logic [31:0] sum, sat, input logic cout, ovf);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.tag = tag; v.cout = cout; v.ovf = ovf;
`ifdef PIPELINED_ADDSUB_SAT_EN
    v.sum = sat;
`else
    v.sum = sum;
`endif
    return v;
  endfunction

  function automatic logic [31:0] opnd();
    logic [31:0] sp [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 32'($urandom);
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.a = opnd(); v.b = opnd(); v.cin = 1'($urandom); v.sub = 1'($urandom); v.tag = 4'($urandom);
    return model(v);
  endfunction

  task automatic drive(input vec_t v);
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_tag = v.tag;
  endtask

  task automatic check_out(input string name, input vec_t e);
    chk({name, "_sum"}, out_sum, e.sum);
    chk({name, "_cout"}, out_cout, e.cout);
    chk({name, "_ovf"}, out_ovf, e.ovf);
    chk({name, "_tag"}, out_tag, e.tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    #1 chk("in_ready_during_rst", in_ready, 0);
    @(negedge clk);
    chk("rst_outputs", {out_valid, out_sum, out_cout, out_ovf, out_tag}, 0);
    rst = 0;
    #1 chk("in_ready_after_rst", in_ready, 1);
    exq.delete();
  endtask

  // single op into an empty pipe; all three depths must emit after exactly STAGES cycles
  task automatic lat_test(input vec_t v);
    int n4 = 0, n1 = 0, n32 = 0;
    @(negedge clk);
    drive(v); in_valid = 1; out_ready = 1;
    #1 chk("lat_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    for (int n = 1; n <= 40; n++) begin
      if (out_valid && n4 == 0) begin n4 = n; check_out("lat4", v); end
      if (s1_valid && n1 == 0) begin
        n1 = n; chk("lat1_sum", s1_sum, v.sum); chk("lat1_cout", s1_cout, v.cout);
      end
      if (s32_valid && n32 == 0) begin
        n32 = n; chk("lat32_sum", s32_sum, v.sum); chk("lat32_cout", s32_cout, v.cout);
      end
      @(negedge clk);
    end
    chk("latency_s4", n4, 4);
    chk("latency_s1", n1, 1);
    chk("latency_s32", n32, 32);
  endtask

  task automatic run_stream(input bit rnd);
    vec_t cur, e;
    bit acc = 0, stalled = 0;
    logic [41:0] held = '0;
    int guard = 0;
    while ((src.size() != 0 || exq.size() != 0 || acc) && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (acc) in_valid = 0;
      if (stalled) chk("hold_stable", {out_valid, out_sum, out_cout, out_ovf, out_tag}, held);
      if (!in_valid && src.size() != 0) begin
        cur = src.pop_front(); drive(cur); in_valid = 1;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("in_ready_full_only", in_ready, !(exq.size() == 4 && !out_ready));
      if (out_valid && out_ready) begin
        chk("no_spurious_out", exq.size() != 0, 1);
        if (exq.size() != 0) begin e = exq.pop_front(); check_out("stream", e); end
      end
      stalled = out_valid && !out_ready;
      held = {out_valid, out_sum, out_cout, out_ovf, out_tag};
      acc = in_valid && in_ready;
      if (acc) exq.push_back(cur);
    end
    chk("stream_no_timeout", guard < 20000, 1);
    in_valid = 0; out_ready = 1;
  endtask

  initial begin
    tbl[0] = mk(32'hFFFFFFFF, 32'h1, 0, 0, 4'd3, 32'h0, 32'h0, 1, 0);
    tbl[1] = mk(32'h5, 32'h3, 0, 1, 4'd1, 32'h2, 32'h2, 1, 0);
    tbl[2] = mk(32'h3, 32'h5, 0, 1, 4'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0);
    tbl[3] = mk(32'h7FFFFFFF, 32'h1, 0, 0, 4'd4, 32'h80000000, 32'h7FFFFFFF, 0, 1);
    tbl[4] = mk(32'h12345678, 32'h87654321, 0, 0, 4'd5, 32'h99999999, 32'h99999999, 0, 0);
    tbl[5] = mk(32'hAB, 32'hCD, 1, 0, 4'd6, 32'h179, 32'h179, 0, 0);
    tbl[6] = mk(32'hCAFEBABE, 32'h11111111, 0, 0, 4'd7, 32'hDC0FCBCF, 32'hDC0FCBCF, 0, 0);
    tbl[7] = mk(32'h80000000, 32'h1, 0, 1, 4'd8, 32'h7FFFFFFF, 32'h80000000, 1, 1);
    tbl[8] = mk(32'h0, 32'h0, 1, 1, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    tbl[9] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);

    repeat (2) @(negedge clk);
    do_reset();
    lat_test(tbl[6]);

    for (int i = 0; i < 10; i++) src.push_back(tbl[i]);
    run_stream(1);

    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(rnd_vec()); in_valid = 1;
      #1 chk("flush_fill_ready", in_ready, 1);
    end
    do_reset();
    lat_test(tbl[0]);

    for (int i = 0; i < 300; i++) src.push_back(rnd_vec());
    run_stream(1);
    for (int i = 0; i < 40; i++) src.push_back(rnd_vec());
    run_stream(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
